// File: rtl/time_alarm_pkg.sv
// Shared mode encodings, field widths and wrap-around increment helpers
// for the time/alarm datapath.
package time_alarm_pkg;

    localparam int HOURS_W   = 5;
    localparam int MIN_SEC_W = 6;

    localparam logic [HOURS_W-1:0]   MAX_HOURS   = 5'd23;
    localparam logic [MIN_SEC_W-1:0] MAX_MIN_SEC = 6'd59;

    typedef enum logic [1:0] {
        MODE_RUN       = 2'd0,
        MODE_SET_TIME  = 2'd1,
        MODE_SET_ALARM = 2'd2
    } mode_t;

    function automatic logic [HOURS_W-1:0] inc_hours(input logic [HOURS_W-1:0] v);
        return (v == MAX_HOURS) ? '0 : v + HOURS_W'(1);
    endfunction

    function automatic logic [MIN_SEC_W-1:0] inc_min_sec(input logic [MIN_SEC_W-1:0] v);
        return (v == MAX_MIN_SEC) ? '0 : v + MIN_SEC_W'(1);
    endfunction

endpackage

// File: rtl/time_alarm_tick_gen.sv
// Enabled modulo-DIV prescaler: one-cycle tick on the last count, counter
// held at 0 while disabled so a re-enable always starts a full period.
module tick_gen #(
    parameter int DIV = 50_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic en,
    output logic tick
);

    localparam int                CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] count;

    assign tick = en && (count == LAST);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (!en || tick) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/time_alarm_core.sv
// 24 h clock with settable time/alarm and timed ring output.
// Build option: define AUTO_REPEAT_EN for held-button auto-repeat in set modes.
module time_alarm_core
    import time_alarm_pkg::*;
#(
    parameter int TICK_DIV      = 50_000_000,
    parameter int RING_SECONDS  = 60,
    parameter int REPEAT_CYCLES = 12_500_000
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 semnal_setare,
    input  logic                 semnal_setare_a,
    input  logic                 semnal_stop,
    input  logic                 semnal_b1,
    input  logic                 semnal_b2,
    output logic [HOURS_W-1:0]   hours,
    output logic [MIN_SEC_W-1:0] minutes,
    output logic [MIN_SEC_W-1:0] seconds,
    output logic [HOURS_W-1:0]   alarm_h,
    output logic [MIN_SEC_W-1:0] alarm_m,
    output logic [1:0]           mode,
    output logic                 alarm_armed,
    output logic                 alarm_ringing,
    output logic                 led
);

    if (TICK_DIV < 2 || REPEAT_CYCLES < 2 || RING_SECONDS < 1 || RING_SECONDS > 255) begin : g_param_check
        $error("time_alarm_core: parameter out of range");
    end

    mode_t mode_q, mode_d;
    logic  b1_hist, b2_hist, stop_hist, setare_a_hist;
    logic  rise_b1, rise_b2, rise_stop, fall_setare_a;
    logic  in_set_time, in_set_alarm, in_set;
    logic  step_h, step_m;
    logic  tick, arm_set, match;
    logic  [7:0] ring_cnt;
    logic  [HOURS_W-1:0]   nxt_h;
    logic  [MIN_SEC_W-1:0] nxt_m, nxt_s;

    // Input history; zero after reset so a level already high counts as a rise.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            {b1_hist, b2_hist, stop_hist, setare_a_hist} <= '0;
        end else begin
            {b1_hist, b2_hist, stop_hist, setare_a_hist} <=
                {semnal_b1, semnal_b2, semnal_stop, semnal_setare_a};
        end
    end

    assign rise_b1       = semnal_b1 & ~b1_hist;
    assign rise_b2       = semnal_b2 & ~b2_hist;
    assign rise_stop     = semnal_stop & ~stop_hist;
    assign fall_setare_a = ~semnal_setare_a & setare_a_hist;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) mode_q <= MODE_RUN;
        else        mode_q <= mode_d;
    end

    always_comb begin
        mode_d = MODE_RUN;
        if (semnal_setare)        mode_d = MODE_SET_TIME;
        else if (semnal_setare_a) mode_d = MODE_SET_ALARM;
    end

    assign mode         = mode_q;
    assign in_set_time  = (mode_q == MODE_SET_TIME);
    assign in_set_alarm = (mode_q == MODE_SET_ALARM);
    assign in_set       = in_set_time | in_set_alarm;

    // Time-set mode holds the prescaler so RUN resumes with a full second.
    tick_gen #(.DIV(TICK_DIV)) u_sec_tick (
        .clock (clock),
        .reset (reset),
        .en    (!in_set_time),
        .tick  (tick)
    );

`ifdef AUTO_REPEAT_EN
    logic rep_b1, rep_b2;

    // Repeat timers run only while the button stays held past its rise cycle.
    tick_gen #(.DIV(REPEAT_CYCLES)) u_rep_b1 (
        .clock (clock),
        .reset (reset),
        .en    (in_set && semnal_b1 && b1_hist),
        .tick  (rep_b1)
    );

    tick_gen #(.DIV(REPEAT_CYCLES)) u_rep_b2 (
        .clock (clock),
        .reset (reset),
        .en    (in_set && semnal_b2 && b2_hist),
        .tick  (rep_b2)
    );

    assign step_h = rise_b1 | rep_b1;
    assign step_m = rise_b2 | rep_b2;
`else
    assign step_h = rise_b1;
    assign step_m = rise_b2;
`endif

    always_comb begin
        nxt_s = inc_min_sec(seconds);
        nxt_m = (seconds == MAX_MIN_SEC) ? inc_min_sec(minutes) : minutes;
        nxt_h = (seconds == MAX_MIN_SEC && minutes == MAX_MIN_SEC) ? inc_hours(hours) : hours;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hours   <= '0;
            minutes <= '0;
            seconds <= '0;
        end else if (in_set_time) begin
            seconds <= '0;
            if (step_h) hours   <= inc_hours(hours);
            if (step_m) minutes <= inc_min_sec(minutes);
        end else if (tick) begin
            hours   <= nxt_h;
            minutes <= nxt_m;
            seconds <= nxt_s;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            alarm_h <= '0;
            alarm_m <= '0;
        end else if (in_set_alarm) begin
            if (step_h) alarm_h <= inc_hours(alarm_h);
            if (step_m) alarm_m <= inc_min_sec(alarm_m);
        end
    end

    // Mode register moving SET_ALARM -> RUN on this edge.
    assign arm_set = in_set_alarm && fall_setare_a && !semnal_setare;
    assign match   = tick && (mode_q == MODE_RUN) && alarm_armed && !rise_stop &&
                     (nxt_h == alarm_h) && (nxt_m == alarm_m) && (nxt_s == '0);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            alarm_armed   <= 1'b0;
            alarm_ringing <= 1'b0;
            ring_cnt      <= '0;
        end else begin
            if (arm_set)                        alarm_armed <= 1'b1;
            else if (rise_stop && !alarm_ringing) alarm_armed <= 1'b0;

            if (mode_q != MODE_RUN || mode_d != MODE_RUN) begin
                alarm_ringing <= 1'b0;
                ring_cnt      <= '0;
            end else if (alarm_ringing && rise_stop) begin
                alarm_ringing <= 1'b0;
                ring_cnt      <= '0;
            end else if (alarm_ringing && tick) begin
                ring_cnt <= ring_cnt - 8'd1;
                if (ring_cnt == 8'd1) alarm_ringing <= 1'b0;
            end else if (match) begin
                alarm_ringing <= 1'b1;
                ring_cnt      <= 8'(RING_SECONDS);
            end
        end
    end

    assign led = alarm_ringing & seconds[0];

endmodule

// File: tb/tb_time_alarm_core.sv
// Directed bench for time_alarm_core with TICK_DIV=4, RING_SECONDS=3, REPEAT_CYCLES=8.
module tb_time_alarm_core;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       semnal_setare = 1'b0, semnal_setare_a = 1'b0, semnal_stop = 1'b0;
    logic       semnal_b1 = 1'b0, semnal_b2 = 1'b0;
    logic [4:0] hours, alarm_h;
    logic [5:0] minutes, seconds, alarm_m;
    logic [1:0] mode;
    logic       alarm_armed, alarm_ringing, led;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    time_alarm_core #(
        .TICK_DIV      (4),
        .RING_SECONDS  (3),
        .REPEAT_CYCLES (8)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .semnal_setare   (semnal_setare),
        .semnal_setare_a (semnal_setare_a),
        .semnal_stop     (semnal_stop),
        .semnal_b1       (semnal_b1),
        .semnal_b2       (semnal_b2),
        .hours           (hours),
        .minutes         (minutes),
        .seconds         (seconds),
        .alarm_h         (alarm_h),
        .alarm_m         (alarm_m),
        .mode            (mode),
        .alarm_armed     (alarm_armed),
        .alarm_ringing   (alarm_ringing),
        .led             (led)
    );

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        {semnal_setare, semnal_setare_a, semnal_stop, semnal_b1, semnal_b2} = '0;
        cyc(2);
        reset = 1'b1;
    endtask

    task automatic pulses(input int n, input logic p1, input logic p2);
        for (int i = 0; i < n; i++) begin
            semnal_b1 = p1;
            semnal_b2 = p2;
            cyc(1);
            semnal_b1 = 1'b0;
            semnal_b2 = 1'b0;
            cyc(1);
        end
    endtask

    // Alarm 07:30 armed, then time preset to 07:29 and run to 07:29:59.
    task automatic arm_and_preset();
        do_reset();
        semnal_setare_a = 1'b1;
        cyc(1);
        pulses(7, 1'b1, 1'b0);
        pulses(30, 1'b0, 1'b1);
        semnal_setare_a = 1'b0;
        cyc(1);
        semnal_setare = 1'b1;
        cyc(1);
        pulses(7, 1'b1, 1'b0);
        pulses(29, 1'b0, 1'b1);
        semnal_setare = 1'b0;
        cyc(1);
        cyc(236);
    endtask

    task automatic test_reset();
        do_reset();
        total++; if ({hours, minutes, seconds, alarm_h, alarm_m, mode, alarm_armed, alarm_ringing, led} !== '0) begin
            bad++; $display("FAIL reset_state got h=%0d m=%0d s=%0d ah=%0d am=%0d mode=%0d arm=%0d ring=%0d led=%0d exp all 0",
                            hours, minutes, seconds, alarm_h, alarm_m, mode, alarm_armed, alarm_ringing, led);
        end
        cyc(3);
        total++; if (seconds !== 6'd0) begin bad++; $display("FAIL pre_tick_seconds got=%0d exp=0", seconds); end
        cyc(1);
        total++; if ({mode, seconds} !== {2'd0, 6'd1}) begin
            bad++; $display("FAIL first_tick got mode=%0d s=%0d exp mode=0 s=1", mode, seconds);
        end
    endtask

    task automatic test_rollover();
        do_reset();
        semnal_setare = 1'b1;
        cyc(1);
        pulses(23, 1'b1, 1'b0);
        pulses(59, 1'b0, 1'b1);
        semnal_setare = 1'b0;
        cyc(1);
        cyc(232);
        total++; if ({hours, minutes, seconds} !== {5'd23, 6'd59, 6'd58}) begin
            bad++; $display("FAIL preset_235958 got=%0d:%0d:%0d exp=23:59:58", hours, minutes, seconds);
        end
        cyc(4);
        total++; if ({hours, minutes, seconds} !== {5'd23, 6'd59, 6'd59}) begin
            bad++; $display("FAIL time_235959 got=%0d:%0d:%0d exp=23:59:59", hours, minutes, seconds);
        end
        cyc(4);
        total++; if ({hours, minutes, seconds, alarm_ringing, alarm_armed} !== {17'd0, 2'b00}) begin
            bad++; $display("FAIL midnight_wrap got=%0d:%0d:%0d ring=%0d arm=%0d exp=0:0:0 ring=0 arm=0",
                            hours, minutes, seconds, alarm_ringing, alarm_armed);
        end
        pulses(1, 1'b1, 1'b1);
        total++; if ({hours, minutes} !== {5'd0, 6'd0}) begin
            bad++; $display("FAIL run_ignores_buttons got h=%0d m=%0d exp h=0 m=0", hours, minutes);
        end
    endtask

    task automatic test_set_time();
        do_reset();
        semnal_setare = 1'b1;
        cyc(1);
        total++; if (mode !== 2'd1) begin bad++; $display("FAIL set_time_mode got=%0d exp=1", mode); end
        pulses(25, 1'b1, 1'b0);
        total++; if (hours !== 5'd1) begin bad++; $display("FAIL hours_wrap got=%0d exp=1", hours); end
        pulses(61, 1'b0, 1'b1);
        total++; if ({hours, minutes, seconds} !== {5'd1, 6'd1, 6'd0}) begin
            bad++; $display("FAIL minutes_no_carry got=%0d:%0d:%0d exp=1:1:0", hours, minutes, seconds);
        end
        pulses(1, 1'b1, 1'b1);
        total++; if ({hours, minutes} !== {5'd2, 6'd2}) begin
            bad++; $display("FAIL both_buttons got h=%0d m=%0d exp h=2 m=2", hours, minutes);
        end
        cyc(10);
        total++; if (seconds !== 6'd0) begin bad++; $display("FAIL seconds_held got=%0d exp=0", seconds); end
        semnal_setare = 1'b0;
        cyc(4);
        total++; if (seconds !== 6'd0) begin bad++; $display("FAIL resume_full_second got=%0d exp=0", seconds); end
        cyc(1);
        total++; if ({mode, seconds} !== {2'd0, 6'd1}) begin
            bad++; $display("FAIL resume_first_tick got mode=%0d s=%0d exp mode=0 s=1", mode, seconds);
        end
    endtask

    task automatic test_mode_priority();
        do_reset();
        semnal_setare   = 1'b1;
        semnal_setare_a = 1'b1;
        total++; if (mode !== 2'd0) begin bad++; $display("FAIL mode_latency got=%0d exp=0", mode); end
        cyc(1);
        total++; if (mode !== 2'd1) begin bad++; $display("FAIL set_time_priority got=%0d exp=1", mode); end
        semnal_setare = 1'b0;
        cyc(1);
        total++; if ({mode, alarm_armed} !== {2'd2, 1'b0}) begin
            bad++; $display("FAIL set_alarm_mode got mode=%0d arm=%0d exp mode=2 arm=0", mode, alarm_armed);
        end
        semnal_setare_a = 1'b0;
        cyc(1);
        total++; if ({mode, alarm_armed} !== {2'd0, 1'b1}) begin
            bad++; $display("FAIL arm_on_exit got mode=%0d arm=%0d exp mode=0 arm=1", mode, alarm_armed);
        end
    endtask

    task automatic test_alarm_ring();
        arm_and_preset();
        total++; if ({alarm_h, alarm_m, alarm_armed} !== {5'd7, 6'd30, 1'b1}) begin
            bad++; $display("FAIL alarm_setting got=%0d:%0d arm=%0d exp=7:30 arm=1", alarm_h, alarm_m, alarm_armed);
        end
        total++; if ({hours, minutes, seconds, alarm_ringing} !== {5'd7, 6'd29, 6'd59, 1'b0}) begin
            bad++; $display("FAIL before_match got=%0d:%0d:%0d ring=%0d exp=7:29:59 ring=0",
                            hours, minutes, seconds, alarm_ringing);
        end
        cyc(4);
        total++; if ({hours, minutes, seconds, alarm_ringing, led} !== {5'd7, 6'd30, 6'd0, 1'b1, 1'b0}) begin
            bad++; $display("FAIL ring_start got=%0d:%0d:%0d ring=%0d led=%0d exp=7:30:0 ring=1 led=0",
                            hours, minutes, seconds, alarm_ringing, led);
        end
        cyc(4);
        total++; if ({alarm_ringing, led} !== 2'b11) begin
            bad++; $display("FAIL ring_led_on got ring=%0d led=%0d exp ring=1 led=1", alarm_ringing, led);
        end
        cyc(4);
        total++; if ({alarm_ringing, led} !== 2'b10) begin
            bad++; $display("FAIL ring_led_off got ring=%0d led=%0d exp ring=1 led=0", alarm_ringing, led);
        end
        cyc(4);
        total++; if ({seconds, alarm_ringing, led, alarm_armed} !== {6'd3, 1'b0, 1'b0, 1'b1}) begin
            bad++; $display("FAIL ring_timeout got s=%0d ring=%0d led=%0d arm=%0d exp s=3 ring=0 led=0 arm=1",
                            seconds, alarm_ringing, led, alarm_armed);
        end
    endtask

    task automatic test_stop();
        arm_and_preset();
        cyc(6);
        total++; if (alarm_ringing !== 1'b1) begin bad++; $display("FAIL stop_setup_ring got=%0d exp=1", alarm_ringing); end
        semnal_stop = 1'b1;
        cyc(1);
        total++; if ({alarm_ringing, alarm_armed} !== 2'b01) begin
            bad++; $display("FAIL stop_while_ringing got ring=%0d arm=%0d exp ring=0 arm=1", alarm_ringing, alarm_armed);
        end
        semnal_stop = 1'b0;
        cyc(1);
        semnal_stop = 1'b1;
        cyc(1);
        total++; if ({alarm_ringing, alarm_armed} !== 2'b00) begin
            bad++; $display("FAIL stop_disarms got ring=%0d arm=%0d exp ring=0 arm=0", alarm_ringing, alarm_armed);
        end
        cyc(8);
        total++; if ({alarm_ringing, alarm_armed} !== 2'b00) begin
            bad++; $display("FAIL stop_held got ring=%0d arm=%0d exp ring=0 arm=0", alarm_ringing, alarm_armed);
        end
        semnal_stop = 1'b0;
        arm_and_preset();
        cyc(4);
        reset = 1'b0;
        #1;
        total++; if ({hours, minutes, seconds, alarm_h, alarm_m, mode, alarm_armed, alarm_ringing, led} !== '0) begin
            bad++; $display("FAIL reset_mid_ring got h=%0d m=%0d ah=%0d am=%0d arm=%0d ring=%0d exp all 0",
                            hours, minutes, alarm_h, alarm_m, alarm_armed, alarm_ringing);
        end
        cyc(1);
        reset = 1'b1;
    endtask

    task automatic test_repeat();
        logic [4:0] exp_h;
`ifdef AUTO_REPEAT_EN
        exp_h = 5'd3;
`else
        exp_h = 5'd1;
`endif
        do_reset();
        semnal_setare = 1'b1;
        cyc(1);
        semnal_b1 = 1'b1;
        cyc(20);
        semnal_b1 = 1'b0;
        cyc(1);
        total++; if (hours !== exp_h) begin bad++; $display("FAIL held_b1 got=%0d exp=%0d", hours, exp_h); end
        semnal_setare = 1'b0;
        cyc(1);
    endtask

    initial begin
        test_reset();
        test_rollover();
        test_set_time();
        test_mode_priority();
        test_alarm_ring();
        test_stop();
        test_repeat();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
